// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int DATA_W = 64;
  localparam int ARB_STARVE_MAX = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_DONE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM requester handshakes and the single memory port
interface mem_port_arbiter_if #(parameter int ADDR_W = 64);
  import mem_port_arbiter_pkg::*;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_done;
  logic [31:0]       inst_rdata;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_wmask;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, data_wmask,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output inst_done, inst_rdata, data_done, data_rdata,
           mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask
  );
  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, data_wmask,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  inst_done, inst_rdata, data_done, data_rdata,
           mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// arb_grant: data-first priority with an instruction-fetch starvation guard
module arb_grant import mem_port_arbiter_pkg::*; #(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   sample,
  input  logic   inst_req,
  input  logic   data_req,
  output owner_t grant
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  logic starved;
  always_comb begin
    starved = starve_cnt == CW'(STARVE_MAX);
    grant = !sample ? OWN_NONE :
            (inst_req && data_req) ? (starved ? OWN_INST : OWN_DATA) :
            inst_req ? OWN_INST :
            data_req ? OWN_DATA : OWN_NONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_cnt <= '0;
    else if (grant == OWN_INST) starve_cnt <= '0;
    else if (grant == OWN_DATA && inst_req && !starved) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one handshaked 64-bit memory port between instruction fetch and data access
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  arb_state_t state;
  owner_t owner, grant;
  logic hi_sel, resp_now;
  logic [ADDR_W-1:0] sel_addr;
  arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk(clk), .rst_n(rst_n), .sample(state == ARB_IDLE),
    .inst_req(bus.inst_req), .data_req(bus.data_req), .grant(grant)
  );
  always_comb begin
    sel_addr = grant == OWN_DATA ? bus.data_addr : bus.inst_addr;
    resp_now = bus.mem_resp_valid &&
               (state == ARB_RESP || (state == ARB_REQ && bus.mem_req_ready));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= OWN_NONE;
      hi_sel <= 1'b0;
      bus.inst_done <= 1'b0;
      bus.inst_rdata <= '0;
      bus.data_done <= 1'b0;
      bus.data_rdata <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
    end else begin
      bus.inst_done <= resp_now && owner == OWN_INST;
      bus.data_done <= resp_now && owner == OWN_DATA;
      if (resp_now && owner == OWN_INST)
        bus.inst_rdata <= hi_sel ? bus.mem_resp_rdata[63:32] : bus.mem_resp_rdata[31:0];
      if (resp_now && owner == OWN_DATA) bus.data_rdata <= bus.mem_resp_rdata;
      case (state)
        ARB_IDLE: if (grant != OWN_NONE) begin
          owner <= grant;
          state <= ARB_REQ;
          hi_sel <= sel_addr[2];
          bus.mem_req_valid <= 1'b1;
          bus.mem_addr <= sel_addr & ~ADDR_W'(7);
          bus.mem_we <= grant == OWN_DATA && bus.data_we;
          bus.mem_wdata <= grant == OWN_DATA ? bus.data_wdata : '0;
          bus.mem_wmask <= grant == OWN_DATA ? bus.data_wmask : '0;
        end
        ARB_REQ: if (bus.mem_req_ready) begin
          bus.mem_req_valid <= 1'b0;
          state <= bus.mem_resp_valid ? ARB_DONE : ARB_RESP;
        end
        ARB_RESP: if (bus.mem_resp_valid) state <= ARB_DONE;
        default: begin
          state <= ARB_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
endmodule
